// File: rtl/simon_autoplayer.sv
// Simon game autoplayer: watches the game's LED sequence, records up to DEPTH
// colour steps, and once the LEDs have stayed dark for GAP_MS replays the
// sequence on the button outputs with PRESS_MS hold and RELEASE_MS release.
module simon_autoplayer #(
   parameter int DEPTH      = 32,
   parameter int GAP_MS     = 500,
   parameter int PRESS_MS   = 100,
   parameter int RELEASE_MS = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [5:0] ticks_per_milli,
   input  logic [3:0] led,
   output logic [3:0] btn,
   output logic       playing,
   output logic [5:0] seq_len,
   output logic       overflow,
   output logic       game_over
);

   // Millisecond counter must hold the longest of the three timed intervals.
   localparam int MAX_MS = (GAP_MS > PRESS_MS)
                           ? ((GAP_MS > RELEASE_MS) ? GAP_MS : RELEASE_MS)
                           : ((PRESS_MS > RELEASE_MS) ? PRESS_MS : RELEASE_MS);
   localparam int MS_W   = $clog2(MAX_MS + 1);
   localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [MS_W-1:0] GAP_LAST     = MS_W'(GAP_MS - 1);
   localparam logic [MS_W-1:0] PRESS_LAST   = MS_W'(PRESS_MS - 1);
   localparam logic [MS_W-1:0] RELEASE_LAST = MS_W'(RELEASE_MS - 1);
   localparam logic [5:0]      DEPTH_L      = 6'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WATCH,
      S_GAP,
      S_PRESS,
      S_RELEASE
   } state_t;

   state_t          state_q;
   logic [5:0]      tick_cnt_q;
   logic [MS_W-1:0] ms_cnt_q;
   logic [5:0]      seq_len_q;
   logic [5:0]      play_idx_q;
   logic [3:0]      led_prev_q;
   logic [3:0]      btn_q;
   logic            playing_q;
   logic            overflow_q;
   logic            game_over_q;
   logic [1:0]      buf_q [0:DEPTH-1];

   logic [5:0]      tick_last;
   logic            ms_tick;
   logic            led_zero;
   logic            led_multi;
   logic            led_onehot;
   logic [1:0]      led_idx;
   logic            seq_full;
   logic            step_seen;
   logic            rec_step;
   logic [5:0]      next_idx;

   function automatic logic [3:0] idx_to_btn(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

   // Decode the LED bus, derive the ms tick and the step-record strobe.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      led_idx    = 2'd0;
      tick_last  = (ticks_per_milli == 6'd0) ? 6'd0 : ticks_per_milli - 6'd1;
      // >= keeps the prescaler from running away if ticks_per_milli shrinks mid-count.
      ms_tick    = (tick_cnt_q >= tick_last);
      led_zero   = (led == 4'b0000);
      led_multi  = |(led & (led - 4'd1));
      led_onehot = !led_zero && !led_multi;
      unique case (led)
         4'b0010: led_idx = 2'd1;
         4'b0100: led_idx = 2'd2;
         4'b1000: led_idx = 2'd3;
         default: led_idx = 2'd0;
      endcase
      seq_full   = (seq_len_q >= DEPTH_L);
      step_seen  = (state_q == S_WATCH) && enable && (led_prev_q == 4'b0000) && led_onehot;
      rec_step   = step_seen && !seq_full;
      next_idx   = play_idx_q + 6'd1;
   end

   // Step buffer: written only when a new colour is recorded in WATCH.
   // NOTE: the buffer has no reset; its contents are only read below seq_len, so stale data is harmless.
   always_ff @(posedge clk) begin
      if (rec_step) begin
         buf_q[seq_len_q[IDX_W-1:0]] <= led_idx;
      end
   end

   // Main FSM with ms prescaler, step counting and registered outputs.
   always_ff @(posedge clk) begin
      // NOTE: all sequential state uses non-blocking assignment so every register sees pre-edge values.
      if (rst) begin
         state_q     <= S_IDLE;
         tick_cnt_q  <= '0;
         ms_cnt_q    <= '0;
         seq_len_q   <= '0;
         play_idx_q  <= '0;
         led_prev_q  <= '0;
         btn_q       <= '0;
         playing_q   <= 1'b0;
         overflow_q  <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         led_prev_q <= led;
         tick_cnt_q <= ms_tick ? 6'd0 : tick_cnt_q + 6'd1;
         if (ms_tick) begin
            ms_cnt_q <= ms_cnt_q + 1'b1;
         end

         if (!enable) begin
            // Disable wins over everything; recorded steps are kept.
            state_q    <= S_IDLE;
            btn_q      <= '0;
            playing_q  <= 1'b0;
            tick_cnt_q <= '0;
            ms_cnt_q   <= '0;
         end else begin
            unique case (state_q)
               S_IDLE: begin
                  state_q    <= S_WATCH;
                  tick_cnt_q <= '0;
                  ms_cnt_q   <= '0;
               end

               S_WATCH: begin
                  if (led_multi) begin
                     // Several LEDs at once means the game signalled a loss.
                     game_over_q <= 1'b1;
                     seq_len_q   <= '0;
                     tick_cnt_q  <= '0;
                     ms_cnt_q    <= '0;
                  end else if (!led_zero) begin
                     // Any lit LED restarts the dark-time measurement.
                     tick_cnt_q <= '0;
                     ms_cnt_q   <= '0;
                     if (step_seen) begin
                        if (seq_full) begin
                           overflow_q <= 1'b1;
                        end else begin
                           seq_len_q <= seq_len_q + 6'd1;
                        end
                     end
                  end else if (seq_len_q == 6'd0) begin
                     // Nothing to replay yet, so dark time is not measured.
                     tick_cnt_q <= '0;
                     ms_cnt_q   <= '0;
                  end else if (ms_tick && (ms_cnt_q == GAP_LAST)) begin
                     state_q    <= S_GAP;
                     tick_cnt_q <= '0;
                     ms_cnt_q   <= '0;
                  end
               end

               S_GAP: begin
                  state_q    <= S_PRESS;
                  play_idx_q <= '0;
                  btn_q      <= idx_to_btn(buf_q[0]);
                  playing_q  <= 1'b1;
                  tick_cnt_q <= '0;
                  ms_cnt_q   <= '0;
               end

               S_PRESS: begin
                  if (ms_tick && (ms_cnt_q == PRESS_LAST)) begin
                     state_q    <= S_RELEASE;
                     btn_q      <= '0;
                     tick_cnt_q <= '0;
                     ms_cnt_q   <= '0;
                  end
               end

               S_RELEASE: begin
                  if (ms_tick && (ms_cnt_q == RELEASE_LAST)) begin
                     tick_cnt_q <= '0;
                     ms_cnt_q   <= '0;
                     play_idx_q <= next_idx;
                     if (next_idx == seq_len_q) begin
                        // Whole sequence replayed: wait for the game's next, longer round.
                        state_q   <= S_WATCH;
                        seq_len_q <= '0;
                        playing_q <= 1'b0;
                     end else begin
                        state_q <= S_PRESS;
                        btn_q   <= idx_to_btn(buf_q[next_idx[IDX_W-1:0]]);
                     end
                  end
               end

               default: begin
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign btn       = btn_q;
   assign playing   = playing_q;
   assign seq_len   = seq_len_q;
   assign overflow  = overflow_q;
   assign game_over = game_over_q;

endmodule

// File: tb/tb_simon_autoplayer.sv
// Bench for simon_autoplayer: directed LED sequences; expected button presses
// are queued as they are shown and a monitor checks each press as it ends.
module tb_simon_autoplayer;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [5:0] ticks_per_milli;
   logic [3:0] led;
   logic [3:0] btn;
   logic       playing;
   logic [5:0] seq_len;
   logic       overflow;
   logic       game_over;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] val;
      int         len;
      int         rel;   // expected low cycles before this press, -1 = not checked
   } press_t;

   press_t sb_q[$];

   simon_autoplayer dut (
      .clk             (clk),
      .rst             (rst),
      .enable          (enable),
      .ticks_per_milli (ticks_per_milli),
      .led             (led),
      .btn             (btn),
      .playing         (playing),
      .seq_len         (seq_len),
      .overflow        (overflow),
      .game_over       (game_over)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
      end
   endtask

   task automatic push(input logic [3:0] val, input int len, input int rel);
      press_t p;
      p.val = val;
      p.len = len;
      p.rel = rel;
      sb_q.push_back(p);
   endtask

   task automatic show(input logic [3:0] colour, input int on_cyc, input int off_cyc);
      led = colour;
      repeat (on_cyc) @(negedge clk);
      led = 4'b0000;
      repeat (off_cyc) @(negedge clk);
   endtask

   // Bounded waits: n returns the number of negedges taken (limit on timeout).
   task automatic wait_btn_on(input int limit, output int n);
      n = 0;
      while (btn === 4'b0000 && n < limit) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic wait_btn_off(input int limit, output int n);
      n = 0;
      while (btn !== 4'b0000 && n < limit) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic wait_idle(input string name, input int limit);
      int n = 0;
      while (playing !== 1'b0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      check(name, (playing === 1'b0), 1);
   endtask

   // Monitor: one scoreboard entry is consumed each time a press ends.
   logic [3:0] mon_prev = 4'b0000;
   logic [3:0] mon_cur  = 4'b0000;
   int         mon_len  = 0;
   int         mon_low  = 0;
   int         mon_rel  = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (btn !== 4'b0000 && btn !== 4'bxxxx) begin
            if (mon_prev == 4'b0000) begin
               mon_cur = btn;
               mon_len = 1;
               mon_rel = mon_low;
            end else begin
               mon_len++;
            end
            mon_prev = btn;
         end else begin
            if (mon_prev != 4'b0000) begin
               if (sb_q.size() == 0) begin
                  check("unexpected_press", mon_cur, 0);
               end else begin
                  press_t e;
                  e = sb_q.pop_front();
                  check("press_btn", mon_cur, e.val);
                  check("press_len", mon_len, e.len);
                  if (e.rel >= 0) check("release_len", mon_rel, e.rel);
               end
               mon_low = 1;
            end else begin
               mon_low++;
            end
            mon_prev = 4'b0000;
         end
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;

      rst             = 1'b1;
      enable          = 1'b0;
      ticks_per_milli = 6'd4;
      led             = 4'b0000;
      repeat (3) @(negedge clk);
      check("rst_btn",       btn,       0);
      check("rst_playing",   playing,   0);
      check("rst_seq_len",   seq_len,   0);
      check("rst_overflow",  overflow,  0);
      check("rst_game_over", game_over, 0);
      rst = 1'b0;

      // Three colours at 4 clk/ms: 50 ms on, 50 ms off, then dark.
      enable = 1'b1;
      repeat (2) @(negedge clk);
      push(4'b0001, 400, -1);
      push(4'b0100, 400, 400);
      push(4'b0010, 400, 400);
      show(4'b0001, 200, 200);
      show(4'b0100, 200, 200);
      show(4'b0010, 200, 0);
      check("a_seq_len", seq_len, 3);
      wait_btn_on(5000, n);
      check("a_gap_cycles", n, 2001);
      check("a_playing", playing, 1);
      wait_idle("a_done", 5000);
      check("a_seq_len_end", seq_len, 0);
      check("a_btn_end", btn, 0);

      // Long hold records once; same colour after a dark gap records again.
      ticks_per_milli = 6'd1;
      repeat (2) @(negedge clk);
      push(4'b1000, 100, -1);
      push(4'b1000, 100, 100);
      show(4'b1000, 300, 50);
      show(4'b1000, 50, 0);
      check("b_seq_len", seq_len, 2);
      wait_btn_on(1000, n);
      check("b_gap_cycles", n, 501);
      wait_idle("b_done", 1000);
      check("b_seq_len_end", seq_len, 0);

      // Several LEDs lit means game over: sequence dropped, nothing replayed.
      show(4'b0001, 20, 20);
      show(4'b0010, 20, 20);
      show(4'b0100, 20, 20);
      check("c_seq_len_pre", seq_len, 3);
      show(4'b1111, 20, 0);
      check("c_game_over", game_over, 1);
      check("c_seq_len", seq_len, 0);
      repeat (700) @(negedge clk);
      check("c_no_replay_btn", btn, 0);
      check("c_no_replay_playing", playing, 0);

      // 33 steps against a 32-entry buffer.
      for (int i = 0; i < 33; i++) begin
         logic [3:0] c;
         c = 4'b0001 << (i % 4);
         if (i < 32) push(c, 100, (i == 0) ? -1 : 100);
         show(c, 2, 2);
         if (i == 31) begin
            check("d_seq_len_32", seq_len, 32);
            check("d_overflow_pre", overflow, 0);
         end
      end
      check("d_seq_len", seq_len, 32);
      check("d_overflow", overflow, 1);
      check("d_game_over_sticky", game_over, 1);
      wait_btn_on(1000, n);
      check("d_replay_started", (btn !== 4'b0000), 1);
      wait_idle("d_done", 8000);
      check("d_seq_len_end", seq_len, 0);

      // Enable dropped mid-press: press cut short, buffer kept for later.
      push(4'b0100, 31, -1);
      show(4'b0100, 10, 0);
      wait_btn_on(1000, n);
      repeat (30) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      check("e_btn_off", btn, 0);
      check("e_playing_off", playing, 0);
      repeat (3) @(negedge clk);
      check("e_seq_len_kept", seq_len, 1);
      push(4'b0100, 100, -1);
      enable = 1'b1;
      wait_btn_on(1000, n);
      check("e_replay_again", btn, 4'b0100);
      wait_idle("e_done", 1000);

      // Reset in the middle of RELEASE.
      push(4'b0001, 100, -1);
      show(4'b0001, 10, 10);
      show(4'b0010, 10, 0);
      wait_btn_on(1000, n);
      wait_btn_off(200, n);
      repeat (20) @(negedge clk);
      check("f_in_release", playing, 1);
      rst = 1'b1;
      @(negedge clk);
      check("f_rst_btn",       btn,       0);
      check("f_rst_playing",   playing,   0);
      check("f_rst_seq_len",   seq_len,   0);
      check("f_rst_overflow",  overflow,  0);
      check("f_rst_game_over", game_over, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // ticks_per_milli = 0 behaves as one clk per ms.
      ticks_per_milli = 6'd0;
      push(4'b1000, 100, -1);
      show(4'b1000, 5, 0);
      wait_btn_on(1000, n);
      check("g_gap_cycles", n, 501);
      wait_idle("g_done", 1000);

      repeat (5) @(negedge clk);
      check("sb_empty", sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
